// File: rtl/systolic_feeder.sv
// ----------------------------------------------------------------------------
// systolic_feeder
//   Holds two N x N matrices (A and B) loaded one element per beat in
//   row-major order. On start it streams them into the left and top edges
//   of a systolic array with the diagonal skew the array needs. It then
//   waits for the array to drain and pulses done.
//
// Ports
//   clk         sole clock, rising edge
//   rst         asynchronous, active-high reset
//   load_valid  load beat offered
//   load_ready  beat can be accepted (IDLE and start low)
//   load_sel    0 = beat targets A, 1 = beat targets B
//   load_data   element value, row-major order
//   start       request to stream the loaded matrices
//   busy        high while feeding or draining
//   done        one-cycle completion pulse
//   a_row       left-edge values; slice i drives array row i
//   b_col       top-edge values; slice j drives array column j
// ----------------------------------------------------------------------------
module systolic_feeder #(
    parameter int N         = 3,
    parameter int W         = 8,
    parameter int SKEW      = 2,
    parameter int DRAIN_CYC = 2 * N + 2
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           load_valid,
    output logic           load_ready,
    input  logic           load_sel,
    input  logic [W-1:0]   load_data,
    input  logic           start,
    output logic           busy,
    output logic           done,
    output logic [N*W-1:0] a_row,
    output logic [N*W-1:0] b_col
);

    localparam int NN       = N * N;
    localparam int FEED_LEN = N + SKEW * (N - 1);
    localparam int CNT_MAX  = (FEED_LEN > DRAIN_CYC) ? FEED_LEN : DRAIN_CYC;
    localparam int CW       = $clog2(CNT_MAX + 1);
    localparam int IW       = (NN > 1) ? $clog2(NN) : 1;

    localparam logic [CW-1:0] FEED_LAST  = CW'(FEED_LEN - 1);
    localparam logic [CW-1:0] DRAIN_LAST = CW'(DRAIN_CYC - 1);
    localparam logic [IW-1:0] IDX_LAST   = IW'(NN - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FEED  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t         state_r;
    logic [CW-1:0]  cnt_r;
    logic [IW-1:0]  a_idx_r;
    logic [IW-1:0]  b_idx_r;
    logic           a_loaded_r;
    logic           b_loaded_r;
    logic           busy_r;
    logic           done_r;
    logic [N*W-1:0] a_row_r;
    logic [N*W-1:0] b_col_r;
    logic [N*W-1:0] a_row_s;
    logic [N*W-1:0] b_col_s;
    logic           a_wr_s;
    logic           b_wr_s;
    logic [W-1:0]   a_mem_r [NN];
    logic [W-1:0]   b_mem_r [NN];

    assign load_ready = (state_r == IDLE) && !start;
    assign a_wr_s     = load_valid && load_ready && !load_sel;
    assign b_wr_s     = load_valid && load_ready && load_sel;

    assign busy  = busy_r;
    assign done  = done_r;
    assign a_row = a_row_r;
    assign b_col = b_col_r;

    // Element storage; deliberately left unreset because its contents are
    // only observable after a full reload.
    always_ff @(posedge clk) begin
        if (a_wr_s) begin
            a_mem_r[a_idx_r] <= load_data;
        end
        if (b_wr_s) begin
            b_mem_r[b_idx_r] <= load_data;
        end
    end

    // Write indices and loaded flags; a full matrix is the beat writing the
    // last index, and restarting at index 0 invalidates it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_idx_r    <= '0;
            b_idx_r    <= '0;
            a_loaded_r <= 1'b0;
            b_loaded_r <= 1'b0;
        end else begin
            if (a_wr_s) begin
                a_idx_r <= (a_idx_r == IDX_LAST) ? '0 : a_idx_r + IW'(1);
                if (a_idx_r == IDX_LAST) begin
                    a_loaded_r <= 1'b1;
                end else if (a_idx_r == '0) begin
                    a_loaded_r <= 1'b0;
                end
            end
            if (b_wr_s) begin
                b_idx_r <= (b_idx_r == IDX_LAST) ? '0 : b_idx_r + IW'(1);
                if (b_idx_r == IDX_LAST) begin
                    b_loaded_r <= 1'b1;
                end else if (b_idx_r == '0) begin
                    b_loaded_r <= 1'b0;
                end
            end
        end
    end

    // Skewed edge values for feed step cnt_r: row/column i lags by SKEW*i
    // steps and shows zero outside its N-step window.
    always_comb begin
        a_row_s = '0;
        b_col_s = '0;
        for (int i = 0; i < N; i++) begin
            if ((int'(cnt_r) >= SKEW * i) && (int'(cnt_r) < SKEW * i + N)) begin
                a_row_s[i*W +: W] = a_mem_r[IW'(i * N + int'(cnt_r) - SKEW * i)];
                b_col_s[i*W +: W] = b_mem_r[IW'((int'(cnt_r) - SKEW * i) * N + i)];
            end else begin
                a_row_s[i*W +: W] = '0;
                b_col_s[i*W +: W] = '0;
            end
        end
    end

    // Sequencer with registered busy/done/edge outputs; cnt_r is the feed
    // step in FEED and the drain count in DRAIN.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            cnt_r   <= '0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            a_row_r <= '0;
            b_col_r <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    a_row_r <= '0;
                    b_col_r <= '0;
                    done_r  <= 1'b0;
                    if (start && a_loaded_r && b_loaded_r) begin
                        state_r <= FEED;
                        cnt_r   <= '0;
                        busy_r  <= 1'b1;
                    end
                end
                FEED: begin
                    a_row_r <= a_row_s;
                    b_col_r <= b_col_s;
                    if (cnt_r == FEED_LAST) begin
                        state_r <= DRAIN;
                        cnt_r   <= '0;
                    end else begin
                        cnt_r <= cnt_r + CW'(1);
                    end
                end
                DRAIN: begin
                    a_row_r <= '0;
                    b_col_r <= '0;
                    if (cnt_r == DRAIN_LAST) begin
                        state_r <= DONE;
                        cnt_r   <= '0;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                    end else begin
                        cnt_r <= cnt_r + CW'(1);
                    end
                end
                DONE: begin
                    a_row_r <= '0;
                    b_col_r <= '0;
                    done_r  <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                    cnt_r   <= '0;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                    a_row_r <= '0;
                    b_col_r <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_systolic_feeder.sv
// ----------------------------------------------------------------------------
// tb_systolic_feeder
//   Self-checking bench for systolic_feeder (N=3, W=8, SKEW=2, DRAIN_CYC=8).
//   A matrix-level reference model (two N x N arrays, per-matrix write
//   counters and loaded flags) predicts every streamed edge value from the
//   skew formula. Directed tables cover load_ready and known stream points;
//   randomized loads and randomized stray inputs exercise the rest.
// ----------------------------------------------------------------------------
module tb_systolic_feeder;

    localparam int N         = 3;
    localparam int W         = 8;
    localparam int SKEW      = 2;
    localparam int DRAIN_CYC = 8;
    localparam int FEED_LEN  = N + SKEW * (N - 1);
    localparam int RUN_LEN   = FEED_LEN + DRAIN_CYC + 1;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           load_valid;
    logic           load_ready;
    logic           load_sel;
    logic [W-1:0]   load_data;
    logic           start;
    logic           busy;
    logic           done;
    logic [N*W-1:0] a_row;
    logic [N*W-1:0] b_col;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    logic [W-1:0] ma [N][N];
    logic [W-1:0] mb [N][N];
    int           ma_idx;
    int           mb_idx;
    bit           ma_ld;
    bit           mb_ld;

    logic [N*W-1:0] cap_a [RUN_LEN + 1];
    logic [N*W-1:0] cap_b [RUN_LEN + 1];

    typedef struct {
        logic st;
        logic lv;
        logic exp_rdy;
    } rdy_vec_t;

    typedef struct {
        int         cyc;
        int         slice;
        logic [W-1:0] ea;
        logic [W-1:0] eb;
    } pt_vec_t;

    rdy_vec_t rdy_tbl [4];
    pt_vec_t  pt_tbl  [7];

    systolic_feeder #(
        .N         (N),
        .W         (W),
        .SKEW      (SKEW),
        .DRAIN_CYC (DRAIN_CYC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_sel   (load_sel),
        .load_data  (load_data),
        .start      (start),
        .busy       (busy),
        .done       (done),
        .a_row      (a_row),
        .b_col      (b_col)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [N*W-1:0] act, input logic [N*W-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        ma_idx = 0;
        mb_idx = 0;
        ma_ld  = 1'b0;
        mb_ld  = 1'b0;
    endtask

    task automatic model_write(input bit sel, input logic [W-1:0] d);
        if (!sel) begin
            ma[ma_idx / N][ma_idx % N] = d;
            if (ma_idx == N * N - 1) ma_ld = 1'b1;
            else if (ma_idx == 0) ma_ld = 1'b0;
            ma_idx = (ma_idx + 1) % (N * N);
        end else begin
            mb[mb_idx / N][mb_idx % N] = d;
            if (mb_idx == N * N - 1) mb_ld = 1'b1;
            else if (mb_idx == 0) mb_ld = 1'b0;
            mb_idx = (mb_idx + 1) % (N * N);
        end
    endtask

    function automatic logic [N*W-1:0] exp_a(input int t);
        logic [N*W-1:0] r;
        r = '0;
        for (int i = 0; i < N; i++) begin
            if (t - SKEW * i >= 0 && t - SKEW * i < N) r[i*W +: W] = ma[i][t - SKEW * i];
        end
        return r;
    endfunction

    function automatic logic [N*W-1:0] exp_b(input int t);
        logic [N*W-1:0] r;
        r = '0;
        for (int j = 0; j < N; j++) begin
            if (t - SKEW * j >= 0 && t - SKEW * j < N) r[j*W +: W] = mb[t - SKEW * j][j];
        end
        return r;
    endfunction

    // One accepted load beat (only used in IDLE with start low).
    task automatic beat(input bit sel, input logic [W-1:0] d);
        load_valid = 1'b1;
        load_sel   = sel;
        load_data  = d;
        start      = 1'b0;
        #1;
        check("load_ready_idle", load_ready, 1'b1);
        @(posedge clk);
        model_write(sel, d);
        #1;
        load_valid = 1'b0;
    endtask

    task automatic pulse_start(output bit acc);
        acc        = ma_ld && mb_ld;
        start      = 1'b1;
        load_valid = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("busy_after_start", busy, acc);
    endtask

    // Checks a whole run starting just after the accept edge (k = 0).
    task automatic check_run(input bit noise);
        for (int k = 0; k <= RUN_LEN; k++) begin
            logic [N*W-1:0] ea;
            logic [N*W-1:0] eb;
            ea = (k >= 1 && k <= FEED_LEN) ? exp_a(k - 1) : '0;
            eb = (k >= 1 && k <= FEED_LEN) ? exp_b(k - 1) : '0;
            cap_a[k] = a_row;
            cap_b[k] = b_col;
            check($sformatf("run_busy_k%0d", k), busy, (k <= FEED_LEN + DRAIN_CYC - 1));
            check($sformatf("run_done_k%0d", k), done, (k == FEED_LEN + DRAIN_CYC));
            check($sformatf("run_ready_k%0d", k), load_ready, (k == RUN_LEN));
            check($sformatf("run_a_row_k%0d", k), a_row, ea);
            check($sformatf("run_b_col_k%0d", k), b_col, eb);
            if (k < RUN_LEN) begin
                if (noise && k <= FEED_LEN + DRAIN_CYC - 2) begin
                    start      = 1'($urandom_range(0, 1));
                    load_valid = 1'($urandom_range(0, 1));
                    load_sel   = 1'($urandom_range(0, 1));
                    load_data  = W'($urandom);
                end else begin
                    start      = 1'b0;
                    load_valid = 1'b0;
                end
                @(posedge clk);
                #1;
            end
        end
        start      = 1'b0;
        load_valid = 1'b0;
    endtask

    // Random interleaved reload of both matrices with gaps and refused beats.
    task automatic load_random();
        int na;
        int nb;
        int r;
        bit sel;
        na = 0;
        nb = 0;
        while (na < N * N || nb < N * N) begin
            r = $urandom_range(0, 3);
            if (r == 0) begin
                if (!(ma_ld && mb_ld) && $urandom_range(0, 1) == 1) begin
                    start      = 1'b1;
                    load_valid = 1'b1;
                    load_sel   = 1'($urandom_range(0, 1));
                    load_data  = W'($urandom);
                    #1;
                    check("ready_low_with_start", load_ready, 1'b0);
                    @(posedge clk);
                    #1;
                    start      = 1'b0;
                    load_valid = 1'b0;
                    check("stray_start_ignored", busy, 1'b0);
                end else begin
                    load_valid = 1'b0;
                    tick();
                end
            end else begin
                if (na >= N * N) sel = 1'b1;
                else if (nb >= N * N) sel = 1'b0;
                else sel = (r == 1) ? 1'b0 : 1'b1;
                beat(sel, W'($urandom));
                if (sel) nb++;
                else na++;
            end
        end
    endtask

    initial begin
        bit acc;
        bit seen_done;

        rdy_tbl[0] = '{1'b0, 1'b0, 1'b1};
        rdy_tbl[1] = '{1'b1, 1'b0, 1'b0};
        rdy_tbl[2] = '{1'b0, 1'b1, 1'b1};
        rdy_tbl[3] = '{1'b1, 1'b1, 1'b0};

        pt_tbl[0] = '{1, 0, 8'h31, 8'hB1};
        pt_tbl[1] = '{1, 1, 8'h00, 8'h00};
        pt_tbl[2] = '{1, 2, 8'h00, 8'h00};
        pt_tbl[3] = '{3, 0, 8'h33, 8'hB7};
        pt_tbl[4] = '{3, 1, 8'h34, 8'hB2};
        pt_tbl[5] = '{5, 1, 8'h36, 8'hB8};
        pt_tbl[6] = '{7, 2, 8'h39, 8'hB9};

        load_valid = 1'b0;
        load_sel   = 1'b0;
        load_data  = '0;
        start      = 1'b0;

        // Reset asserted before any clock edge
        #1 rst = 1'b1;
        #2;
        check("rst_a_row", a_row, '0);
        check("rst_b_col", b_col, '0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
        check("ready_after_rst", load_ready, 1'b1);

        // load_ready against start/load_valid in IDLE (no edge applied)
        for (int v = 0; v < 4; v++) begin
            start      = rdy_tbl[v].st;
            load_valid = rdy_tbl[v].lv;
            #1;
            check($sformatf("rdy_tbl%0d", v), load_ready, rdy_tbl[v].exp_rdy);
        end
        start      = 1'b0;
        load_valid = 1'b0;
        tick();

        // Only A loaded: start must be ignored
        for (int k = 0; k < N * N; k++) beat(1'b0, W'(8'h31 + k));
        pulse_start(acc);
        for (int k = 0; k < 3; k++) begin
            tick();
            check("a_only_busy", busy, 1'b0);
            check("a_only_ready", load_ready, 1'b1);
        end

        // Load B, run and compare against known stream points
        for (int k = 0; k < N * N; k++) beat(1'b1, W'(8'hB1 + k));
        pulse_start(acc);
        check_run(1'b0);
        for (int p = 0; p < 7; p++) begin
            check($sformatf("pt%0d_a", p), cap_a[pt_tbl[p].cyc][pt_tbl[p].slice*W +: W], pt_tbl[p].ea);
            check($sformatf("pt%0d_b", p), cap_b[pt_tbl[p].cyc][pt_tbl[p].slice*W +: W], pt_tbl[p].eb);
        end

        // Second start re-streams the same data, with stray inputs mid-run
        pulse_start(acc);
        check_run(1'b1);

        // Randomized reloads and runs
        for (int it = 0; it < 4; it++) begin
            load_random();
            pulse_start(acc);
            check_run(1'b1);
        end

        // Reset in the middle of FEED
        pulse_start(acc);
        tick();
        tick();
        tick();
        rst = 1'b1;
        #1;
        check("midrst_a_row", a_row, '0);
        check("midrst_b_col", b_col, '0);
        check("midrst_busy", busy, 1'b0);
        check("midrst_done", done, 1'b0);
        tick();
        rst = 1'b0;
        model_reset();
        seen_done = 1'b0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (done) seen_done = 1'b1;
        end
        check("midrst_no_done", seen_done, 1'b0);
        pulse_start(acc);
        tick();
        tick();
        check("midrst_no_restart", busy, 1'b0);

        // Index wrap: 10 A beats invalidate A, 8 more restore it
        for (int v = 1; v <= 10; v++) beat(1'b0, W'(v));
        for (int k = 0; k < N * N; k++) beat(1'b1, W'($urandom));
        pulse_start(acc);
        tick();
        check("wrap_not_loaded", busy, 1'b0);
        for (int v = 11; v <= 18; v++) beat(1'b0, W'(v));
        pulse_start(acc);
        check_run(1'b0);
        check("wrap_a00", cap_a[1][W-1:0], 8'd10);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
